pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Control FSM that drives the PC register's source select and load enable each cycle.
- Sequences the boot fetch from the reset vector, normal increment, taken branch/call/return, and interrupt entry, including a multi-cycle PC push to the stack.
- Sits in the fetch stage and arbitrates among stall, branch and interrupt requests arriving from decode/execute and the interrupt pin.

Parameters:
- PUSH_CYCLES, 2: cycles spent pushing the return PC on interrupt entry (legal range 1..15).
- NEST_DEPTH, 4: maximum nested interrupt depth; used only when the optional feature is compiled in.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- mem_ready  input  1  instruction memory ready; gates the boot fetch.
- stall  input  1  pipeline stall; freezes the PC and the FSM.
- branch_taken  input  1  execute-stage taken branch, call or return; target is on the branch/call address input of the PC mux.
- rti  input  1  qualifies branch_taken as a return-from-interrupt.
- int_req  input  1  external interrupt request, level-sensitive.
- pc_sel  output  2  PC source select: 00 next, 01 first instruction, 10 interrupt vector, 11 branch/call target.
- pc_en  output  1  PC load enable.
- flush  output  1  squash younger instructions in fetch/decode.
- push_pc  output  1  request stack unit to store the current PC this cycle.
- int_ack  output  1  one-cycle acknowledge of interrupt acceptance.
- in_isr  output  1  handler active.

Behaviour:
- Reset (asynchronous, any state, including mid-push):
  - State goes to BOOT; push counter = 0; int_pending = 0; in_isr = 0.
  - Outputs: pc_sel = 00, pc_en = 0, flush = 0, push_pc = 0, int_ack = 0.
- Outputs are combinational decode of the registered state plus the current inputs. The PC loads on the same clock edge.
- int_pending:
  - Set on any clk edge with int_req = 1.
  - Cleared on the edge where int_ack = 1.
  - int_req while already pending has no further effect.
- BOOT:
  - mem_ready = 0: pc_en = 0.
  - mem_ready = 1: pc_en = 1, pc_sel = 01; go to RUN.
  - stall is ignored in BOOT.
  - int_pending can set during BOOT but is not serviced until RUN.
- RUN, priority order within a cycle:
  1. stall = 1: pc_en = 0, no other output asserted, state held. branch_taken is ignored; the requester holds it.
  2. branch_taken = 1: pc_en = 1, pc_sel = 11, flush = 1. If rti = 1, in_isr clears on this edge.
  3. int_pending = 1 and in_isr = 0: pc_en = 0, flush = 1, int_ack = 1; counter loaded with PUSH_CYCLES; go to INT_PUSH.
  4. Otherwise: pc_en = 1, pc_sel = 00.
- Branch and interrupt in the same cycle: the branch wins. The interrupt is taken the next non-stalled cycle, so the pushed PC is the branch target.
- rti together with int_pending: in_isr clears that edge; the interrupt is accepted the following cycle at the earliest.
- INT_PUSH:
  - pc_en = 0, push_pc = 1.
  - Counter decrements each non-stalled cycle.
  - stall = 1 holds the counter and deasserts push_pc.
  - When counter = 1 and not stalled, go to INT_JUMP.
  - Branches are ignored.
- INT_JUMP: pc_en = 1, pc_sel = 10; in_isr sets; go to RUN. stall holds the state.
- Interrupt latency: from int_ack to vector load = PUSH_CYCLES + 1 cycles with no stalls.

Optional Feature:
- Macro: PC_SEQ_NESTED_INT_EN.
- Defined:
  - in_isr is replaced internally by a depth counter, width clog2(NEST_DEPTH+1).
  - INT_JUMP increments the counter; rti with branch_taken decrements it. Decrement at 0 saturates at 0.
  - Condition 3 requires depth < NEST_DEPTH instead of in_isr = 0.
  - Output in_isr = (depth != 0).
- Undefined: single-level behaviour as above; NEST_DEPTH unused.

Test Plan:
- Boot: rst pulse, mem_ready low 3 cycles then high → pc_en = 0 for 3 cycles, then one cycle pc_en = 1 with pc_sel = 01, then pc_sel = 00 every cycle.
- Interrupt: int_req pulse in RUN, PUSH_CYCLES = 2 → int_ack and flush next cycle, push_pc for 2 cycles, then pc_sel = 10 with pc_en = 1, and in_isr = 1.
- Conflict: branch_taken and int_pending in the same cycle → pc_sel = 11 with flush; int_ack follows the next cycle.
- Stall: stall = 1 for 2 cycles during INT_PUSH → push_pc low and counter held; total entry takes 5 cycles.
- Return/mask: second int_req while in_isr = 1 → no ack until branch_taken with rti = 1, then int_ack on the following cycle.
- Reset mid-push: assert rst during INT_PUSH → all outputs 0 immediately, state BOOT, int_pending cleared.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage control FSM that picks the PC source and load
// enable each cycle. It sequences the boot fetch, sequential increment, taken
// branch/call/return, and interrupt entry with a multi-cycle return-PC push.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   mem_ready     instruction memory ready, gates the boot fetch
//   stall         pipeline stall, freezes the PC and the FSM
//   branch_taken  execute-stage taken branch/call/return
//   rti           qualifies branch_taken as a return-from-interrupt
//   int_req       level-sensitive external interrupt request
//   pc_sel        00 next, 01 first instruction, 10 int vector, 11 branch target
//   pc_en         PC load enable
//   flush         squash younger instructions in fetch/decode
//   push_pc       stack unit stores the current PC this cycle
//   int_ack       one-cycle interrupt acceptance strobe
//   in_isr        handler active
//
// Outputs are a combinational decode of the registered state and the current
// inputs, so the PC register loads on the same edge.
//
// Optional build macro PC_SEQ_NESTED_INT_EN: replaces the single in-handler
// flag with a nesting depth counter limited to NEST_DEPTH.

module pc_sequencer #(
    parameter int unsigned PUSH_CYCLES = 2,
    parameter int unsigned NEST_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_ready,
    input  logic       stall,
    input  logic       branch_taken,
    input  logic       rti,
    input  logic       int_req,
    output logic [1:0] pc_sel,
    output logic       pc_en,
    output logic       flush,
    output logic       push_pc,
    output logic       int_ack,
    output logic       in_isr
);

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] SEL_NEXT   = 2'b00;
    localparam logic [1:0] SEL_BOOT   = 2'b01;
    localparam logic [1:0] SEL_VECTOR = 2'b10;
    localparam logic [1:0] SEL_BRANCH = 2'b11;

    // Reject parameter values outside the supported range at elaboration.
    if (PUSH_CYCLES < 1 || PUSH_CYCLES > 15 || NEST_DEPTH < 1) begin : g_param_check
        $error("pc_sequencer: PUSH_CYCLES must be 1..15 and NEST_DEPTH >= 1");
    end

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_INT_PUSH,
        ST_INT_JUMP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             int_pending;
    logic             can_accept;
    logic             take_rti;
    logic             enter_isr;

    assign take_rti  = (state == ST_RUN) && !stall && branch_taken && rti;
    assign enter_isr = (state == ST_INT_JUMP) && !stall;

`ifdef PC_SEQ_NESTED_INT_EN
    localparam int unsigned DEPTH_W = $clog2(NEST_DEPTH + 1);

    logic [DEPTH_W-1:0] depth;

    // Nesting depth: up on vector load, down on return, floored at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth <= '0;
        end else if (enter_isr && (depth < DEPTH_W'(NEST_DEPTH))) begin
            depth <= depth + DEPTH_W'(1);
        end else if (take_rti && (depth != '0)) begin
            depth <= depth - DEPTH_W'(1);
        end
    end

    assign can_accept = (depth < DEPTH_W'(NEST_DEPTH));
    assign in_isr     = (depth != '0);
`else
    logic isr_active;

    // Single-level handler flag: set on vector load, cleared by return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            isr_active <= 1'b0;
        end else if (enter_isr) begin
            isr_active <= 1'b1;
        end else if (take_rti) begin
            isr_active <= 1'b0;
        end
    end

    assign can_accept = !isr_active;
    assign in_isr     = isr_active;
`endif

    // Latch interrupt requests until acknowledged; the ack edge clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_pending <= 1'b0;
        end else if (int_ack) begin
            int_pending <= 1'b0;
        end else if (int_req) begin
            int_pending <= 1'b1;
        end
    end

    // State and push counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BOOT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and push counter update.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_BOOT: begin
                if (mem_ready) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // A taken branch outranks a pending interrupt, so the pushed
                // PC is the branch target one cycle later.
                if (!stall && !branch_taken && int_pending && can_accept) begin
                    cnt_nxt   = CNT_W'(PUSH_CYCLES);
                    state_nxt = ST_INT_PUSH;
                end
            end
            ST_INT_PUSH: begin
                if (!stall) begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = ST_INT_JUMP;
                    end
                end
            end
            ST_INT_JUMP: begin
                if (!stall) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_BOOT;
        endcase
    end

    // Output decode; forced quiet while reset is asserted.
    always_comb begin
        pc_sel  = SEL_NEXT;
        pc_en   = 1'b0;
        flush   = 1'b0;
        push_pc = 1'b0;
        int_ack = 1'b0;
        if (!rst) begin
            case (state)
                ST_BOOT: begin
                    if (mem_ready) begin
                        pc_en  = 1'b1;
                        pc_sel = SEL_BOOT;
                    end
                end
                ST_RUN: begin
                    if (stall) begin
                        pc_en = 1'b0;
                    end else if (branch_taken) begin
                        pc_en  = 1'b1;
                        pc_sel = SEL_BRANCH;
                        flush  = 1'b1;
                    end else if (int_pending && can_accept) begin
                        flush   = 1'b1;
                        int_ack = 1'b1;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
                ST_INT_PUSH: begin
                    push_pc = !stall;
                end
                ST_INT_JUMP: begin
                    if (!stall) begin
                        pc_en  = 1'b1;
                        pc_sel = SEL_VECTOR;
                    end
                end
                default: pc_en = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer (default build, PUSH_CYCLES = 2).
// Outputs are compared as a packed word {pc_sel, pc_en, flush, push_pc,
// int_ack, in_isr}; inputs change 1 time unit after the rising edge and
// outputs are sampled on the falling edge.

module tb_pc_sequencer;

    logic       clk;
    logic       rst;
    logic       mem_ready;
    logic       stall;
    logic       branch_taken;
    logic       rti;
    logic       int_req;
    logic [1:0] pc_sel;
    logic       pc_en;
    logic       flush;
    logic       push_pc;
    logic       int_ack;
    logic       in_isr;
    logic [6:0] outs;

    int unsigned n_pass;
    int unsigned n_total;

    // Expected output words: {pc_sel, pc_en, flush, push_pc, int_ack, in_isr}
    localparam logic [6:0] O_IDLE     = 7'b00_0_0_0_0_0;
    localparam logic [6:0] O_BOOT     = 7'b01_1_0_0_0_0;
    localparam logic [6:0] O_NEXT     = 7'b00_1_0_0_0_0;
    localparam logic [6:0] O_NEXT_ISR = 7'b00_1_0_0_0_1;
    localparam logic [6:0] O_ACK      = 7'b00_0_1_0_1_0;
    localparam logic [6:0] O_PUSH     = 7'b00_0_0_1_0_0;
    localparam logic [6:0] O_VECTOR   = 7'b10_1_0_0_0_0;
    localparam logic [6:0] O_BR       = 7'b11_1_1_0_0_0;
    localparam logic [6:0] O_BR_ISR   = 7'b11_1_1_0_0_1;
    localparam logic [6:0] O_STALL_ISR= 7'b00_0_0_0_0_1;

    pc_sequencer #(
        .PUSH_CYCLES(2),
        .NEST_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_ready   (mem_ready),
        .stall       (stall),
        .branch_taken(branch_taken),
        .rti         (rti),
        .int_req     (int_req),
        .pc_sel      (pc_sel),
        .pc_en       (pc_en),
        .flush       (flush),
        .push_pc     (push_pc),
        .int_ack     (int_ack),
        .in_isr      (in_isr)
    );

    assign outs = {pc_sel, pc_en, flush, push_pc, int_ack, in_isr};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b (sel,en,flush,push,ack,isr)", tag, obs, exp);
        end
    endtask

    // Check outputs at the falling edge, then advance past the next rising edge.
    task automatic cyc(input string tag, input logic [6:0] exp);
        @(negedge clk);
        check(tag, outs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input logic s, input logic b, input logic r, input logic i);
        mem_ready    = m;
        stall        = s;
        branch_taken = b;
        rti          = r;
        int_req      = i;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        cyc("reset_quiet", O_IDLE);
        rst = 1'b0;

        // Boot: memory not ready for three cycles, then the first fetch.
        for (int i = 0; i < 3; i++) cyc("boot_wait", O_IDLE);
        drive(1, 0, 0, 0, 0);
        cyc("boot_fetch", O_BOOT);
        cyc("run_next0", O_NEXT);
        drive(1, 1, 0, 0, 0);
        cyc("run_stall", O_IDLE);
        drive(1, 0, 0, 0, 0);
        cyc("run_next1", O_NEXT);

        // Interrupt entry with two push cycles.
        drive(1, 0, 0, 0, 1);
        cyc("int_req_cycle", O_NEXT);
        drive(1, 0, 0, 0, 0);
        cyc("int_ack", O_ACK);
        cyc("int_push0", O_PUSH);
        cyc("int_push1", O_PUSH);
        cyc("int_vector", O_VECTOR);
        cyc("isr_run", O_NEXT_ISR);

        // Return from interrupt clears in_isr on that edge.
        drive(1, 0, 1, 1, 0);
        cyc("rti_branch", O_BR_ISR);
        drive(1, 0, 0, 0, 0);
        cyc("after_rti", O_NEXT);

        // Branch and pending interrupt together: branch first, ack next.
        drive(1, 0, 0, 0, 1);
        cyc("conf_req", O_NEXT);
        drive(1, 0, 1, 0, 0);
        cyc("conf_branch", O_BR);
        drive(1, 0, 0, 0, 0);
        cyc("conf_ack", O_ACK);

        // Two stall cycles inside the push hold the counter.
        drive(1, 1, 0, 0, 0);
        cyc("push_stall0", O_IDLE);
        cyc("push_stall1", O_IDLE);
        drive(1, 0, 0, 0, 0);
        cyc("push_after_stall0", O_PUSH);
        cyc("push_after_stall1", O_PUSH);
        cyc("stall_vector", O_VECTOR);
        cyc("isr_run2", O_NEXT_ISR);

        // Second request is masked while the handler runs.
        drive(1, 0, 0, 0, 1);
        cyc("mask_req", O_NEXT_ISR);
        drive(1, 0, 0, 0, 0);
        cyc("mask_hold", O_NEXT_ISR);
        drive(1, 1, 1, 1, 0);
        cyc("mask_stall_branch", O_STALL_ISR);
        drive(1, 0, 1, 1, 0);
        cyc("mask_rti", O_BR_ISR);
        drive(1, 0, 0, 0, 0);
        cyc("mask_ack", O_ACK);
        cyc("mask_push0", O_PUSH);

        // Reset mid-push: outputs drop at once even with mem_ready high.
        #1;
        check("push_before_rst", outs, O_PUSH);
        rst = 1'b1;
        #1;
        check("rst_mid_push", outs, O_IDLE);
        @(posedge clk);
        #1;
        check("rst_held", outs, O_IDLE);
        rst = 1'b0;
        cyc("reboot_fetch", O_BOOT);
        cyc("reboot_run0", O_NEXT);
        cyc("reboot_run1", O_NEXT);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
